// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared state encoding, opcode constants, ALU codes and the
//            opcode-class record used by the control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Sequencer state encoding
  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T1W  = 4'd3;
  localparam logic [3:0] ST_T2   = 4'd4;
  localparam logic [3:0] ST_T3   = 4'd5;
  localparam logic [3:0] ST_T4   = 4'd6;
  localparam logic [3:0] ST_T5   = 4'd7;
  localparam logic [3:0] ST_T6   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // ALU operation codes that are not simply the instruction opcode
  localparam logic [4:0] ALU_INC = 5'd12;
  localparam logic [4:0] ALU_NOT = 5'd13;
  localparam logic [4:0] ALU_NEG = 5'd17;

  // One-hot instruction class produced by the decoder
  typedef struct packed {
    logic two_op;
    logic unary;
    logic muldiv;
    logic nop;
    logic halt;
  } op_class_t;

  // Register-to-register ALU ops occupy a contiguous opcode range
  function automatic logic is_two_operand(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : opcode_decoder
// Purpose  : Combinational classifier of IR[31:27] into instruction classes.
//            Build option MULDIV_EN: when undefined, mul/div decode as nop.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output op_class_t  o_class
);

  // Exactly one class bit is set for every opcode; anything unknown is a nop
  always_comb begin
    o_class = '0;
    if (is_two_operand(i_opcode)) begin
      o_class.two_op = 1'b1;
    end else if ((i_opcode == OP_NEG) || (i_opcode == OP_NOT)) begin
      o_class.unary = 1'b1;
    end else if ((i_opcode == OP_MUL) || (i_opcode == OP_DIV)) begin
`ifdef MULDIV_EN
      o_class.muldiv = 1'b1;
`else
      o_class.nop = 1'b1;
`endif
    end else if (i_opcode == OP_HALT) begin
      o_class.halt = 1'b1;
    end else begin
      o_class.nop = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Moore control FSM for a bus-based CPU: fetch (T0-T2 with a
//            memory wait state T1W), decode at T3, execute T3-T6, HALT.
//            Build option MULDIV_EN enables the mul/div execute sequence and
//            the Zhighout/HIin/LOin strobes; otherwise those are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Rout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  ALU_Control,
  output logic        Run
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [4:0] w_opcode;
  op_class_t  w_class;
  logic       w_unused_ir;

  assign w_opcode    = IR[31:27];
  // Register-field bits are decoded by the datapath, not here
  assign w_unused_ir = ^IR[26:0];

  opcode_decoder u_dec (
    .i_opcode (w_opcode),
    .o_class  (w_class)
  );

  // State register; clr wins over everything, including a pending memory wait
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:  w_next = ST_T0;
      ST_T0:   w_next = ST_T1;
      ST_T1,
      ST_T1W:  w_next = mem_ready ? ST_T2 : ST_T1W;
      ST_T2:   w_next = ST_T3;
      ST_T3: begin
        if (w_class.nop)       w_next = ST_T0;
        else if (w_class.halt) w_next = ST_HALT;
        else                   w_next = ST_T4;
      end
      ST_T4:   w_next = w_class.unary  ? ST_T0 : ST_T5;
      ST_T5:   w_next = w_class.muldiv ? ST_T6 : ST_T0;
      ST_T6:   w_next = ST_T0;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

  // Moore outputs from present state and the decoded IR
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    Rout  = 1'b0; MARin   = 1'b0; PCin     = 1'b0; MDRin  = 1'b0;
    IRin  = 1'b0; Yin     = 1'b0; Zin      = 1'b0; HIin   = 1'b0;
    LOin  = 1'b0; Rin     = 1'b0; Read     = 1'b0;
    Gra   = 1'b0; Grb     = 1'b0; Grc      = 1'b0;
    ALU_Control = 5'd0;
    Run = (r_state != ST_RST) && (r_state != ST_HALT);
    case (r_state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = ALU_INC;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T1W: begin
        Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        if (w_class.two_op) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_class.unary) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
          ALU_Control = (w_opcode == OP_NOT) ? ALU_NOT : ALU_NEG;
        end
`ifdef MULDIV_EN
        else if (w_class.muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
`endif
      end
      ST_T4: begin
        if (w_class.two_op) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_Control = w_opcode;
        end else if (w_class.unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
`ifdef MULDIV_EN
        else if (w_class.muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_Control = w_opcode;
        end
`endif
      end
      ST_T5: begin
        if (w_class.two_op) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
`ifdef MULDIV_EN
        else if (w_class.muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end
`endif
      end
`ifdef MULDIV_EN
      ST_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Directed self-checking bench for control_sequencer.
//            Build option MULDIV_EN selects the mul expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        mem_ready = 1'b1;
  logic PCout, Zlowout, Zhighout, MDRout, Rout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, HIin, LOin, Rin, Read, Gra, Grb, Grc, Run;
  logic [4:0] ALU_Control;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Rout(Rout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALU_Control(ALU_Control), .Run(Run)
  );

  // All single-bit outputs packed into one word for compact comparison
  logic [18:0] obs;
  assign obs = {PCout, Zlowout, Zhighout, MDRout, Rout, MARin, PCin, MDRin,
                IRin, Yin, Zin, HIin, LOin, Rin, Read, Gra, Grb, Grc, Run};

  localparam logic [18:0] M_PCOUT = 19'b1 << 18;
  localparam logic [18:0] M_ZLOW  = 19'b1 << 17;
  localparam logic [18:0] M_ZHIGH = 19'b1 << 16;
  localparam logic [18:0] M_MDROUT= 19'b1 << 15;
  localparam logic [18:0] M_ROUT  = 19'b1 << 14;
  localparam logic [18:0] M_MARIN = 19'b1 << 13;
  localparam logic [18:0] M_PCIN  = 19'b1 << 12;
  localparam logic [18:0] M_MDRIN = 19'b1 << 11;
  localparam logic [18:0] M_IRIN  = 19'b1 << 10;
  localparam logic [18:0] M_YIN   = 19'b1 << 9;
  localparam logic [18:0] M_ZIN   = 19'b1 << 8;
  localparam logic [18:0] M_HIIN  = 19'b1 << 7;
  localparam logic [18:0] M_LOIN  = 19'b1 << 6;
  localparam logic [18:0] M_RIN   = 19'b1 << 5;
  localparam logic [18:0] M_READ  = 19'b1 << 4;
  localparam logic [18:0] M_GRA   = 19'b1 << 3;
  localparam logic [18:0] M_GRB   = 19'b1 << 2;
  localparam logic [18:0] M_GRC   = 19'b1 << 1;
  localparam logic [18:0] M_RUN   = 19'b1;

  localparam logic [18:0] E_T0  = M_PCOUT | M_MARIN | M_ZIN | M_RUN;
  localparam logic [18:0] E_T1  = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [18:0] E_T1W = M_READ | M_MDRIN | M_RUN;
  localparam logic [18:0] E_T2  = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [18:0] E_IDLE= M_RUN;
  localparam logic [18:0] E_OFF = 19'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse clr for one edge; DUT sits in RST afterwards
  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    IR = 32'h0;
    do_reset();
    total++;
    if (obs !== E_OFF || ALU_Control !== 5'd0) begin
      bad++;
      $display("FAIL reset: ctl=%05h alu=%0d expected ctl=%05h alu=0", obs, ALU_Control, E_OFF);
    end
    tick();
    total++;
    if (obs !== E_T0 || ALU_Control !== 5'd12) begin
      bad++;
      $display("FAIL reset_to_t0: ctl=%05h alu=%0d expected ctl=%05h alu=12", obs, ALU_Control, E_T0);
    end
  endtask

  // and r1,r2,r3 with memory always ready: T0..T5 then T0
  task automatic test_two_operand();
    logic [18:0] e [7] = '{E_T0, E_T1, E_T2, M_GRB | M_ROUT | M_YIN | M_RUN,
                           M_GRC | M_ROUT | M_ZIN | M_RUN,
                           M_ZLOW | M_GRA | M_RIN | M_RUN, E_T0};
    logic [4:0]  a [7] = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd12};
    IR = 32'h28918000;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (obs !== e[i] || ALU_Control !== a[i]) begin
        bad++;
        $display("FAIL and step %0d: ctl=%05h alu=%0d expected ctl=%05h alu=%0d", i, obs, ALU_Control, e[i], a[i]);
      end
    end
  endtask

  // not with three memory wait cycles in fetch
  task automatic test_mem_wait();
    logic        mr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [18:0] e  [9] = '{E_T0, E_T1, E_T1W, E_T1W, E_T1W, E_T2,
                            M_GRB | M_ROUT | M_ZIN | M_RUN,
                            M_ZLOW | M_GRA | M_RIN | M_RUN, E_T0};
    logic [4:0]  a  [9] = '{5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd13, 5'd0, 5'd12};
    IR = 32'h90000000;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      tick();
      total++;
      if (obs !== e[i] || ALU_Control !== a[i]) begin
        bad++;
        $display("FAIL not_wait step %0d: ctl=%05h alu=%0d expected ctl=%05h alu=%0d", i, obs, ALU_Control, e[i], a[i]);
      end
    end
    mem_ready = 1'b1;
  endtask

  // neg selects the NEG ALU code in T3
  task automatic test_neg();
    IR = 32'h88000000;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (obs !== (M_GRB | M_ROUT | M_ZIN | M_RUN) || ALU_Control !== 5'd17) begin
      bad++;
      $display("FAIL neg_t3: ctl=%05h alu=%0d expected ctl=%05h alu=17", obs, ALU_Control, M_GRB | M_ROUT | M_ZIN | M_RUN);
    end
  endtask

  // nop and an unknown opcode: empty T3 then straight back to T0
  task automatic test_nop();
    logic [31:0] irs [2] = '{32'hD0000000, 32'hF8000000};
    for (int k = 0; k < 2; k++) begin
      IR = irs[k];
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      tick();
      total++;
      if (obs !== E_IDLE || ALU_Control !== 5'd0) begin
        bad++;
        $display("FAIL nop_t3 ir=%08h: ctl=%05h alu=%0d expected ctl=%05h alu=0", irs[k], obs, ALU_Control, E_IDLE);
      end
      tick();
      total++;
      if (obs !== E_T0) begin
        bad++;
        $display("FAIL nop_next ir=%08h: ctl=%05h expected ctl=%05h", irs[k], obs, E_T0);
      end
    end
  endtask

  // halt: stays stopped for 20 cycles, only clr restarts
  task automatic test_halt();
    int stuck;
    IR = 32'hD8000000;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs !== E_OFF || ALU_Control !== 5'd0) stuck++;
    end
    total++;
    if (stuck != 0) begin
      bad++;
      $display("FAIL halt_hold: %0d of 20 cycles not halted, last ctl=%05h expected ctl=%05h", stuck, obs, E_OFF);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (obs !== E_OFF) begin
      bad++;
      $display("FAIL halt_clr: ctl=%05h expected ctl=%05h", obs, E_OFF);
    end
    tick();
    total++;
    if (obs !== E_T0) begin
      bad++;
      $display("FAIL halt_restart: ctl=%05h expected ctl=%05h", obs, E_T0);
    end
  endtask

  // clr in T4 of add, and clr in the middle of a memory wait
  task automatic test_clr_abort();
    IR = 32'h18000000;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (obs !== (M_GRC | M_ROUT | M_ZIN | M_RUN) || ALU_Control !== 5'd3) begin
      bad++;
      $display("FAIL add_t4: ctl=%05h alu=%0d expected ctl=%05h alu=3", obs, ALU_Control, M_GRC | M_ROUT | M_ZIN | M_RUN);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (obs !== E_OFF || ALU_Control !== 5'd0) begin
      bad++;
      $display("FAIL clr_in_t4: ctl=%05h alu=%0d expected ctl=%05h alu=0", obs, ALU_Control, E_OFF);
    end
    tick();
    total++;
    if (obs !== E_T0) begin
      bad++;
      $display("FAIL clr_in_t4_next: ctl=%05h expected ctl=%05h", obs, E_T0);
    end
    mem_ready = 1'b0;
    tick();
    tick();
    total++;
    if (obs !== E_T1W) begin
      bad++;
      $display("FAIL wait_entry: ctl=%05h expected ctl=%05h", obs, E_T1W);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mem_ready = 1'b1;
    total++;
    if (obs !== E_OFF) begin
      bad++;
      $display("FAIL clr_in_t1w: ctl=%05h expected ctl=%05h", obs, E_OFF);
    end
  endtask

  // mul: full hi/lo sequence when enabled, otherwise a nop
  task automatic test_muldiv();
`ifdef MULDIV_EN
    logic [18:0] e [5] = '{M_GRA | M_ROUT | M_YIN | M_RUN,
                           M_GRB | M_ROUT | M_ZIN | M_RUN,
                           M_ZLOW | M_LOIN | M_RUN,
                           M_ZHIGH | M_HIIN | M_RUN, E_T0};
    logic [4:0]  a [5] = '{5'd0, 5'd15, 5'd0, 5'd0, 5'd12};
`else
    logic [18:0] e [2] = '{E_IDLE, E_T0};
    logic [4:0]  a [2] = '{5'd0, 5'd12};
`endif
    IR = 32'h78000000;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < $size(e); i++) begin
      tick();
      total++;
      if (obs !== e[i] || ALU_Control !== a[i]) begin
        bad++;
        $display("FAIL mul step %0d: ctl=%05h alu=%0d expected ctl=%05h alu=%0d", i, obs, ALU_Control, e[i], a[i]);
      end
    end
  endtask

  // Two instructions with no reset in between
  task automatic test_back_to_back();
    IR = 32'h20000000;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    IR = 32'h90000000;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (obs !== (M_GRB | M_ROUT | M_ZIN | M_RUN) || ALU_Control !== 5'd13) begin
      bad++;
      $display("FAIL b2b_t3: ctl=%05h alu=%0d expected ctl=%05h alu=13", obs, ALU_Control, M_GRB | M_ROUT | M_ZIN | M_RUN);
    end
  endtask

  initial begin
    test_reset();
    test_two_operand();
    test_mem_wait();
    test_neg();
    test_nop();
    test_halt();
    test_clr_abort();
    test_muldiv();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
